// File: rtl/julia_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : julia_dispatch_ctrl
// Description : Frame-level scheduler for the Julia work dispatcher. Clears
//               and steps the pix_inc x/y counter, hands each coordinate to
//               an idle compute core chosen round-robin, and flags frame
//               completion once every core has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module julia_dispatch_ctrl #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_CNT_BITS = 10
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CNT_BITS-1:0] frame_x_max,
  input  logic [NUM_CNT_BITS-1:0] frame_y_max,
  input  logic [NUM_CNT_BITS-1:0] cnt_x,
  input  logic [NUM_CNT_BITS-1:0] cnt_y,
  input  logic                    cnt_last,
  output logic                    cnt_enable,
  output logic                    cnt_clear,
  output logic [NUM_CNT_BITS-1:0] cnt_x_max,
  output logic [NUM_CNT_BITS-1:0] cnt_y_max,
  input  logic [NUM_CORES-1:0]    core_idle,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CNT_BITS-1:0] core_x,
  output logic [NUM_CNT_BITS-1:0] core_y,
  output logic                    frame_busy,
  output logic                    frame_done
);

  // Core index width; one extra bit is kept for the wrap-around sum.
  localparam int                 c_IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [c_IDX_W:0]   c_NUM_CORES = (c_IDX_W + 1)'(NUM_CORES);
  localparam logic [c_IDX_W-1:0] c_LAST_CORE = c_IDX_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_DISPATCH = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_IDX_W-1:0]        r_last_grant;
  logic [NUM_CNT_BITS-1:0]   r_x_max;
  logic [NUM_CNT_BITS-1:0]   r_y_max;
  logic [NUM_CORES-1:0]      r_core_start;
  logic [NUM_CNT_BITS-1:0]   r_core_x;
  logic [NUM_CNT_BITS-1:0]   r_core_y;

  logic [NUM_CORES-1:0]      w_elig;
  logic [c_IDX_W:0]          w_sum;
  logic                      w_grant_valid;
  logic [c_IDX_W-1:0]        w_grant_idx;
  logic [NUM_CORES-1:0]      w_grant_onehot;
  logic                      w_do_grant;
  logic                      w_drained;
  logic                      w_accept_start;

  // A core granted last cycle still shows idle until it samples its pulse,
  // so it is masked out by its own core_start bit.
  assign w_elig = core_idle & ~r_core_start;

  // Round-robin search: the nearest eligible core after last_grant wins.
  // The loop walks from farthest to nearest so the nearest hit is kept.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = r_last_grant;
    w_sum         = '0;
    for (int i = NUM_CORES; i >= 1; i--) begin
      w_sum = {1'b0, r_last_grant} + (c_IDX_W + 1)'(i);
      if (w_sum >= c_NUM_CORES) begin
        w_sum = w_sum - c_NUM_CORES;
      end
      if (w_elig[w_sum[c_IDX_W-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_sum[c_IDX_W-1:0];
      end
    end
  end

  // Decode the chosen core index into the one-hot start vector.
  always_comb begin
    w_grant_onehot              = '0;
    w_grant_onehot[w_grant_idx] = 1'b1;
  end

  assign w_do_grant     = (r_state == S_DISPATCH) && w_grant_valid && !abort;
  assign w_drained      = (&core_idle) && (r_core_start == '0);
  assign w_accept_start = (r_state == S_IDLE) && start && !abort;

  // Frame sequencing: next state, with abort overriding every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_CLEAR;
      S_CLEAR:    w_state_nxt = S_DISPATCH;
      S_DISPATCH: if (w_do_grant && cnt_last) w_state_nxt = S_DRAIN;
      S_DRAIN:    if (w_drained) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame limits are captured only when a start is accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_x_max <= '0;
      r_y_max <= '0;
    end else if (w_accept_start) begin
      r_x_max <= frame_x_max;
      r_y_max <= frame_y_max;
    end
  end

  // Issue register: one-cycle start pulse plus the coordinate it carries.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_core_start <= '0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_last_grant <= c_LAST_CORE;
    end else begin
      r_core_start <= w_do_grant ? w_grant_onehot : '0;
      if (w_do_grant) begin
        r_core_x     <= cnt_x;
        r_core_y     <= cnt_y;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  // The counter steps only on a grant that does not consume the last pixel.
  assign cnt_enable = w_do_grant && !cnt_last;
  assign cnt_clear  = (r_state == S_CLEAR);
  assign cnt_x_max  = r_x_max;
  assign cnt_y_max  = r_y_max;
  assign core_start = r_core_start;
  assign core_x     = r_core_x;
  assign core_y     = r_core_y;
  assign frame_busy = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_julia_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_julia_dispatch_ctrl
// Description : Self-checking bench for julia_dispatch_ctrl with a pix_inc
//               counter model, per-core busy models and a raster/round-robin
//               reference for every issued pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_julia_dispatch_ctrl;

  localparam int NC = 4;
  localparam int NB = 10;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          abort;
  logic [NB-1:0] frame_x_max;
  logic [NB-1:0] frame_y_max;
  logic [NB-1:0] cnt_x;
  logic [NB-1:0] cnt_y;
  logic          cnt_last;
  logic          cnt_enable;
  logic          cnt_clear;
  logic [NB-1:0] cnt_x_max;
  logic [NB-1:0] cnt_y_max;
  logic [NC-1:0] core_idle;
  logic [NC-1:0] core_start;
  logic [NB-1:0] core_x;
  logic [NB-1:0] core_y;
  logic          frame_busy;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  logic [NC-1:0] core_mask;
  int            busy_lo = 1;
  int            busy_hi = 1;
  int            busy [NC];
  int            exp_last;
  bit            last_unknown;
  int            first_core;

  always #5 tb_clk = ~tb_clk;

  julia_dispatch_ctrl #(.NUM_CORES(NC), .NUM_CNT_BITS(NB)) dut (
    .clk(tb_clk), .n_rst(n_rst), .start(start), .abort(abort),
    .frame_x_max(frame_x_max), .frame_y_max(frame_y_max),
    .cnt_x(cnt_x), .cnt_y(cnt_y), .cnt_last(cnt_last),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
    .cnt_x_max(cnt_x_max), .cnt_y_max(cnt_y_max),
    .core_idle(core_idle), .core_start(core_start),
    .core_x(core_x), .core_y(core_y),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  // pix_inc model: raster counter, x fastest.
  always @(posedge tb_clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (cnt_clear) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (cnt_enable) begin
      if (cnt_x == cnt_x_max) begin
        cnt_x <= '0;
        cnt_y <= (cnt_y == cnt_y_max) ? '0 : cnt_y + 1'b1;
      end else begin
        cnt_x <= cnt_x + 1'b1;
      end
    end
  end
  assign cnt_last = (cnt_x == cnt_x_max) && (cnt_y == cnt_y_max);

  // Core models: a sampled start pulse makes the core busy for a random time.
  always @(posedge tb_clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NC; i++) busy[i] <= 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) busy[i] <= $urandom_range(busy_hi, busy_lo);
        else if (busy[i] > 0) busy[i] <= busy[i] - 1;
      end
    end
  end
  always_comb begin
    core_idle = '0;
    for (int i = 0; i < NC; i++) core_idle[i] = core_mask[i] && (busy[i] == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Nearest eligible core after the previous winner, with wrap-around.
  function automatic int rr_pick(input int last, input logic [NC-1:0] elig);
    for (int k = 1; k <= NC; k++) begin
      if (elig[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [NC-1:0] v);
    for (int k = 0; k < NC; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_x"}, core_x, 0);
    chk({tag, "_core_y"}, core_y, 0);
    chk({tag, "_cnt_enable"}, cnt_enable, 0);
    chk({tag, "_cnt_clear"}, cnt_clear, 0);
    chk({tag, "_cnt_x_max"}, cnt_x_max, 0);
    chk({tag, "_cnt_y_max"}, cnt_y_max, 0);
    chk({tag, "_frame_busy"}, frame_busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Runs one frame and checks every issued pixel against the raster order
  // and the round-robin choice. abort_after>0 aborts after that many pulses.
  task automatic run_frame(input int xm, input int ym, input logic [NC-1:0] mask,
                           input int blo, input int bhi, input bit mid_start,
                           input int abort_after);
    int pixels, pulses, enables, cyc, cond_cyc, exp_core;
    bit done_seen;
    logic [NC-1:0] prev_elig;
    pixels = (xm + 1) * (ym + 1);
    pulses = 0; enables = 0; cyc = 0; cond_cyc = -1; done_seen = 0;
    first_core = -1;
    busy_lo = blo; busy_hi = bhi; core_mask = mask;
    @(negedge tb_clk);
    frame_x_max = NB'(xm);
    frame_y_max = NB'(ym);
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    chk("clear_pulse", cnt_clear, 1);
    chk("clear_busy", frame_busy, 1);
    chk("clear_no_enable", cnt_enable, 0);
    chk("latched_x_max", cnt_x_max, xm);
    chk("latched_y_max", cnt_y_max, ym);
    prev_elig = core_idle & ~core_start;
    while (!done_seen && cyc < 3000) begin
      @(negedge tb_clk);
      cyc++;
      start = mid_start && frame_busy && !frame_done && ($urandom_range(2, 0) == 0);
      if (start) begin
        frame_x_max = NB'($urandom_range(9, 0));
        frame_y_max = NB'($urandom_range(9, 0));
      end
      if (core_start !== '0) begin
        chk("start_onehot", $onehot(core_start), 1);
        if (last_unknown) begin
          exp_core = idx_of(core_start);
          last_unknown = 0;
        end else begin
          exp_core = rr_pick(exp_last, prev_elig);
        end
        chk("grant_core", core_start, (exp_core >= 0) ? (32'd1 << exp_core) : 32'd0);
        if (pulses == 0) first_core = idx_of(core_start);
        chk("pulse_in_range", pulses < pixels, 1);
        chk("core_x", core_x, pulses % (xm + 1));
        chk("core_y", core_y, pulses / (xm + 1));
        if (exp_core >= 0) exp_last = exp_core;
        pulses++;
      end
      if (cnt_enable) enables++;
      if ((core_idle & ~core_start) == '0) chk("enable_without_eligible", cnt_enable, 0);
      if (abort_after > 0 && pulses == abort_after) begin
        abort = 1'b1;
        @(negedge tb_clk);
        abort = 1'b0;
        chk("abort_core_start", core_start, 0);
        chk("abort_busy", frame_busy, 0);
        chk("abort_done", frame_done, 0);
        core_mask = '1;
        for (int k = 0; k < 8; k++) begin
          @(negedge tb_clk);
          chk("abort_no_done", frame_done, 0);
        end
        last_unknown = 1;
        start = 1'b0;
        return;
      end
      if (pulses == pixels) core_mask = '1;
      if (frame_done) begin
        done_seen = 1;
        chk("done_timing", cyc, cond_cyc + 1);
        chk("pixel_count", pulses, pixels);
        chk("enable_count", enables, pixels - 1);
        chk("done_x_max_kept", cnt_x_max, xm);
        chk("done_y_max_kept", cnt_y_max, ym);
        chk("done_cores_idle", core_idle, {NC{1'b1}});
      end else if (cond_cyc < 0 && pulses == pixels && core_idle == '1 && core_start == '0) begin
        cond_cyc = cyc;
      end
      prev_elig = core_idle & ~core_start;
    end
    start = 1'b0;
    if (!done_seen) chk("frame_timeout", 0, 1);
    @(negedge tb_clk);
    chk("post_done_busy", frame_busy, 0);
    chk("post_done_pulse", frame_done, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    frame_x_max = '0; frame_y_max = '0; core_mask = '1;
    exp_last = NC - 1; last_unknown = 0;
    #2;
    check_all_zero("reset");
    @(negedge tb_clk);
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
    check_all_zero("post_reset");

    // 3/1 frame, all cores idle, 3-cycle busy: cores 0,1,2,3,0,1,2,3.
    run_frame(3, 1, 4'b1111, 3, 3, 0, 0);
    chk("frame1_first_core", first_core, 0);

    // Single pixel frame.
    run_frame(0, 0, 4'b1111, 2, 4, 0, 0);

    // Only core 2 available, 5-cycle busy.
    run_frame(2, 0, 4'b0100, 5, 5, 0, 0);
    chk("core2_only_first", first_core, 2);

    // Abort after 5 grants of a 9/9 frame, then a clean restart.
    run_frame(9, 9, 4'b1111, 2, 4, 0, 5);
    run_frame(1, 1, 4'b1111, 1, 3, 0, 0);

    // Start pulses during the frame must be ignored.
    run_frame(2, 2, 4'b1111, 1, 5, 1, 0);
    run_frame(4, 1, 4'b0011, 2, 6, 1, 0);

    // Randomized frames.
    for (int r = 0; r < 5; r++) begin
      run_frame($urandom_range(4, 0), $urandom_range(3, 0), NC'($urandom_range(15, 1)),
                1, $urandom_range(6, 1), $urandom_range(1, 0) == 1, 0);
    end

    // Asynchronous reset in the middle of a frame.
    core_mask = '1; busy_lo = 2; busy_hi = 4;
    @(negedge tb_clk);
    frame_x_max = NB'(5); frame_y_max = NB'(5); start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    repeat (10) @(negedge tb_clk);
    @(posedge tb_clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge tb_clk);
    n_rst = 1'b1;
    exp_last = NC - 1; last_unknown = 0;
    run_frame(2, 1, 4'b1111, 1, 3, 0, 0);
    chk("after_reset_first_core", first_core, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
